reorder_buffer: RTL and testbench

//  In-order commit tracker between rename and the back end. It is the driving end of the

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer_ptr.sv | 21 ++
 rtl/reorder_buffer.sv | 127 ++++++++++++
 tb/tb_reorder_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and the default-width entry layout for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH     = 16;
   localparam int unsigned ROB_TAG_WIDTH = $clog2(ROB_DEPTH);
   localparam int unsigned AREG_WIDTH    = 3;
   localparam int unsigned PREG_WIDTH    = 5;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  misp;
      logic                  dest_v;
      logic [AREG_WIDTH-1:0] areg;
      logic [PREG_WIDTH-1:0] preg;
      logic [PREG_WIDTH-1:0] old_preg;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Circular pointer with an extra wrap bit; load takes priority over increment.
module reorder_buffer_ptr
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = ROB_TAG_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               load,
   input  logic [TAG_WIDTH:0] load_val,
   output logic [TAG_WIDTH:0] ptr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       ptr <= '0;
      else if (load) ptr <= load_val;
      else if (inc)  ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit tracker: allocates in program order, completes out of order,
// retires one head entry per cycle and raises a flush on a mispredicted head branch.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ROB_DEPTH  = reorder_buffer_pkg::ROB_DEPTH,
   parameter int unsigned AREG_WIDTH = reorder_buffer_pkg::AREG_WIDTH,
   parameter int unsigned PREG_WIDTH = reorder_buffer_pkg::PREG_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         alloc_v_i,
   output logic                         alloc_ready_o,
   input  logic                         alloc_dest_v_i,
   input  logic [AREG_WIDTH-1:0]        alloc_areg_i,
   input  logic [PREG_WIDTH-1:0]        alloc_preg_i,
   input  logic [PREG_WIDTH-1:0]        alloc_old_preg_i,
   output logic [$clog2(ROB_DEPTH)-1:0] alloc_tag_o,
   input  logic                         complete_v_i,
   input  logic [$clog2(ROB_DEPTH)-1:0] complete_tag_i,
   input  logic                         complete_mispredict_i,
   output logic                         commit_v_o,
   output logic                         commit_rename_o,
   output logic [AREG_WIDTH-1:0]        commit_areg_o,
   output logic [PREG_WIDTH-1:0]        commit_preg_o,
   output logic [PREG_WIDTH-1:0]        commit_old_preg_o,
   output logic                         mispredict_o
);

   localparam int unsigned TW = $clog2(ROB_DEPTH);

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  misp;
      logic                  dest_v;
      logic [AREG_WIDTH-1:0] areg;
      logic [PREG_WIDTH-1:0] preg;
      logic [PREG_WIDTH-1:0] old_preg;
   } entry_t;

   entry_t          rob [ROB_DEPTH];
   entry_t          head_e;
   logic [TW:0]     head, tail, head_next;
   logic [TW-1:0]   head_idx, tail_idx;
   logic            commit_now, flush_now, full, alloc_fire;

   assign head_idx    = head[TW-1:0];
   assign tail_idx    = tail[TW-1:0];
   assign head_next   = head + 1'b1;
   assign alloc_tag_o = tail_idx;

   always_comb begin
      head_e        = rob[head_idx];
      commit_now    = head_e.valid & head_e.done;
      flush_now     = commit_now & head_e.misp;
      full          = (head_idx == tail_idx) && (head[TW] != tail[TW]);
      alloc_ready_o = !full && !flush_now;
      alloc_fire    = alloc_v_i && alloc_ready_o;
   end

   reorder_buffer_ptr #(.TAG_WIDTH(TW)) u_head (
      .clk      (clk_i),
      .rst      (reset_i),
      .inc      (commit_now),
      .load     (1'b0),
      .load_val ('0),
      .ptr      (head)
   );

   // A flush empties the buffer by pulling tail to just past the retiring branch.
   reorder_buffer_ptr #(.TAG_WIDTH(TW)) u_tail (
      .clk      (clk_i),
      .rst      (reset_i),
      .inc      (alloc_fire),
      .load     (flush_now),
      .load_val (head_next),
      .ptr      (tail)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
      end else if (flush_now) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            rob[i].valid <= 1'b0;
            rob[i].done  <= 1'b0;
         end
      end else begin
         // Commit is written after completion so a repeat completion cannot revive a retired head.
         if (complete_v_i && rob[complete_tag_i].valid) begin
            rob[complete_tag_i].done <= 1'b1;
            rob[complete_tag_i].misp <= complete_mispredict_i;
         end
         if (commit_now) begin
            rob[head_idx].valid <= 1'b0;
            rob[head_idx].done  <= 1'b0;
         end
         if (alloc_fire) begin
            rob[tail_idx] <= '{valid: 1'b1, done: 1'b0, misp: 1'b0,
                               dest_v: alloc_dest_v_i, areg: alloc_areg_i,
                               preg: alloc_preg_i, old_preg: alloc_old_preg_i};
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         commit_v_o        <= 1'b0;
         commit_rename_o   <= 1'b0;
         commit_areg_o     <= '0;
         commit_preg_o     <= '0;
         commit_old_preg_o <= '0;
         mispredict_o      <= 1'b0;
      end else begin
         commit_v_o      <= commit_now;
         commit_rename_o <= commit_now & head_e.dest_v;
         mispredict_o    <= flush_now;
         if (commit_now) begin
            commit_areg_o     <= head_e.areg;
            commit_preg_o     <= head_e.preg;
            commit_old_preg_o <= head_e.old_preg;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer against a queue-based in-order model.
module tb_reorder_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alloc_v = 1'b0, alloc_dest_v = 1'b0;
   logic [2:0] alloc_areg = '0;
   logic [4:0] alloc_preg = '0, alloc_old_preg = '0;
   logic       complete_v = 1'b0, complete_mispredict = 1'b0;
   logic [3:0] complete_tag = '0;
   logic       alloc_ready, commit_v, commit_rename, mispredict;
   logic [3:0] alloc_tag;
   logic [2:0] commit_areg;
   logic [4:0] commit_preg, commit_old_preg;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   reorder_buffer #(.ROB_DEPTH(16), .AREG_WIDTH(3), .PREG_WIDTH(5)) dut (
      .clk_i                 (clk),
      .reset_i               (rst),
      .alloc_v_i             (alloc_v),
      .alloc_ready_o         (alloc_ready),
      .alloc_dest_v_i        (alloc_dest_v),
      .alloc_areg_i          (alloc_areg),
      .alloc_preg_i          (alloc_preg),
      .alloc_old_preg_i      (alloc_old_preg),
      .alloc_tag_o           (alloc_tag),
      .complete_v_i          (complete_v),
      .complete_tag_i        (complete_tag),
      .complete_mispredict_i (complete_mispredict),
      .commit_v_o            (commit_v),
      .commit_rename_o       (commit_rename),
      .commit_areg_o         (commit_areg),
      .commit_preg_o         (commit_preg),
      .commit_old_preg_o     (commit_old_preg),
      .mispredict_o          (mispredict)
   );

   always #5 clk = ~clk;

   // Reference model: program-order queue of live instructions plus per-tag status.
   typedef struct {
      int         tag;
      logic       dv;
      logic [2:0] areg;
      logic [4:0] preg;
      logic [4:0] oldp;
   } rec_t;

   rec_t       q[$];
   rec_t       hd;
   logic       m_valid [16];
   logic       m_done  [16];
   logic       m_misp  [16];
   int         m_next = 0;
   logic       mc, mf, mr;
   logic       e_v = 1'b0, e_ren = 1'b0, e_misp = 1'b0;
   logic [2:0] e_areg = '0;
   logic [4:0] e_preg = '0, e_old = '0;

   function automatic logic m_ready();
      return (q.size() < 16) && !(q.size() > 0 && m_done[q[0].tag] && m_misp[q[0].tag]);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_done[i] = 1'b0; m_misp[i] = 1'b0;
         end
         m_next = 0; e_v = 1'b0; e_ren = 1'b0; e_misp = 1'b0;
      end else begin
         mr = m_ready();
         mc = q.size() > 0 && m_done[q[0].tag];
         mf = mc && m_misp[q[0].tag];
         e_v = mc; e_misp = mf; e_ren = 1'b0;
         if (complete_v && !mf && m_valid[complete_tag]) begin
            m_done[complete_tag] = 1'b1;
            m_misp[complete_tag] = complete_mispredict;
         end
         if (mc) begin
            hd = q.pop_front();
            e_ren = hd.dv; e_areg = hd.areg; e_preg = hd.preg; e_old = hd.oldp;
            m_valid[hd.tag] = 1'b0; m_done[hd.tag] = 1'b0;
         end
         if (mf) begin
            foreach (q[i]) begin
               m_valid[q[i].tag] = 1'b0; m_done[q[i].tag] = 1'b0;
            end
            q.delete();
            m_next = (hd.tag + 1) % 16;
         end else if (alloc_v && mr) begin
            q.push_back('{m_next, alloc_dest_v, alloc_areg, alloc_preg, alloc_old_preg});
            m_valid[m_next] = 1'b1; m_done[m_next] = 1'b0; m_misp[m_next] = 1'b0;
            m_next = (m_next + 1) % 16;
         end
      end
   end

   task automatic step(input logic av, input logic dv, input logic [4:0] old,
                       input logic cv, input logic [3:0] ct, input logic cm);
      alloc_v = av; alloc_dest_v = dv; alloc_old_preg = old;
      alloc_areg = 3'($urandom); alloc_preg = 5'($urandom);
      complete_v = cv; complete_tag = ct; complete_mispredict = cm;
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
         checks++;
         if (commit_v !== 1'b0 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got commit_v=%b mispredict=%b, expected 0 0", commit_v, mispredict);
         end
      end
      alloc_v = 1'b0; complete_v = 1'b0; rst = 1'b0;
      #1;
      checks++;
      if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
         errors++;
         $display("FAIL reset_release: got ready=%b tag=%0d, expected 1 0", alloc_ready, alloc_tag);
      end
   endtask

   task automatic test_in_order();
      int seen_old[$];
      int seen_cyc[$];
      int c1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (alloc_tag !== 4'(i)) begin
            errors++;
            $display("FAIL inorder_tag: got %0d, expected %0d", alloc_tag, i);
         end
         step(1, 1, 5'(9 + i), 0, 0, 0);
      end
      c1 = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 0)      step(0, 0, 0, 1, 4'd2, 0);
         else if (i == 1) step(0, 0, 0, 1, 4'd0, 0);
         else if (i == 2) begin c1 = cyc; step(0, 0, 0, 1, 4'd1, 0); end
         else             step(0, 0, 0, 0, 0, 0);
         checks++;
         if (commit_v !== e_v || mispredict !== e_misp ||
             (e_v && {commit_rename, commit_areg, commit_preg, commit_old_preg} !== {e_ren, e_areg, e_preg, e_old})) begin
            errors++;
            $display("FAIL inorder_commit: got v=%b r=%b old=%0d, expected v=%b r=%b old=%0d",
                     commit_v, commit_rename, commit_old_preg, e_v, e_ren, e_old);
         end
         if (commit_v === 1'b1) begin
            seen_old.push_back(int'(commit_old_preg));
            seen_cyc.push_back(cyc);
         end
      end
      checks++;
      if (seen_old.size() != 3 || seen_old[0] != 9 || seen_old[1] != 10 || seen_old[2] != 11) begin
         errors++;
         $display("FAIL inorder_sequence: got %p, expected 9 10 11", seen_old);
      end
      checks++;
      if (seen_cyc.size() != 3 || seen_cyc[1] != c1 + 2 || seen_cyc[0] != c1 + 1 || seen_cyc[2] != c1 + 3) begin
         errors++;
         $display("FAIL inorder_timing: got cycles %p, expected %0d %0d %0d", seen_cyc, c1 + 1, c1 + 2, c1 + 3);
      end
   endtask

   task automatic test_full();
      int n_commit;
      int last_old;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (alloc_tag !== 4'(i) || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: got tag=%0d ready=%b, expected tag=%0d ready=1", alloc_tag, alloc_ready, i);
         end
         step(1, 1, 5'(i), 0, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b, expected 0", alloc_ready);
         end
         step(1, 1, 5'd31, 0, 0, 0);
      end
      n_commit = 0; last_old = -1;
      step(0, 0, 0, 1, 4'd0, 0);
      step(0, 0, 0, 0, 0, 0);
      if (commit_v === 1'b1) begin n_commit++; last_old = int'(commit_old_preg); end
      checks++;
      if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
         errors++;
         $display("FAIL full_wrap_ready: got ready=%b tag=%0d, expected 1 0", alloc_ready, alloc_tag);
      end
      step(1, 1, 5'd20, 0, 0, 0);
      for (int i = 1; i <= 21; i++) begin
         if (i <= 15)      step(0, 0, 0, 1, 4'(i), 0);
         else if (i == 16) step(0, 0, 0, 1, 4'd0, 0);
         else              step(0, 0, 0, 0, 0, 0);
         checks++;
         if (commit_v !== e_v || mispredict !== e_misp ||
             (e_v && {commit_rename, commit_areg, commit_preg, commit_old_preg} !== {e_ren, e_areg, e_preg, e_old})) begin
            errors++;
            $display("FAIL full_commit: got v=%b old=%0d, expected v=%b old=%0d", commit_v, commit_old_preg, e_v, e_old);
         end
         if (commit_v === 1'b1) begin n_commit++; last_old = int'(commit_old_preg); end
      end
      checks++;
      if (n_commit != 17 || last_old != 20) begin
         errors++;
         $display("FAIL full_count: got %0d commits last_old=%0d, expected 17 and 20", n_commit, last_old);
      end
   endtask

   task automatic test_mispredict();
      int olds[$];
      logic mps[$];
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 1, 5'(i), 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 0)      step(0, 0, 0, 1, 4'd1, 1);
         else if (i == 1) step(0, 0, 0, 1, 4'd0, 0);
         else if (i == 2) begin
            step(0, 0, 0, 1, 4'd2, 0);
            checks++;
            if (alloc_ready !== 1'b0) begin
               errors++;
               $display("FAIL misp_flush_ready: got %b, expected 0", alloc_ready);
            end
         end
         else if (i == 3) step(0, 0, 0, 1, 4'd3, 0);
         else             step(0, 0, 0, 0, 0, 0);
         checks++;
         if (commit_v !== e_v || mispredict !== e_misp || alloc_ready !== m_ready() ||
             (e_v && {commit_rename, commit_old_preg} !== {e_ren, e_old})) begin
            errors++;
            $display("FAIL misp_commit: got v=%b m=%b ready=%b old=%0d, expected v=%b m=%b ready=%b old=%0d",
                     commit_v, mispredict, alloc_ready, commit_old_preg, e_v, e_misp, m_ready(), e_old);
         end
         if (commit_v === 1'b1) begin olds.push_back(int'(commit_old_preg)); mps.push_back(mispredict); end
      end
      checks++;
      if (olds.size() != 2 || olds[0] != 0 || olds[1] != 1 || mps[0] !== 1'b0 || mps[1] !== 1'b1) begin
         errors++;
         $display("FAIL misp_sequence: got olds=%p misps=%p, expected 0 1 with flags 0 1", olds, mps);
      end
      checks++;
      if (alloc_tag !== 4'd2 || alloc_ready !== 1'b1) begin
         errors++;
         $display("FAIL misp_next_tag: got tag=%0d ready=%b, expected 2 1", alloc_tag, alloc_ready);
      end
   endtask

   task automatic test_no_dest();
      logic saw;
      do_reset();
      step(1, 0, 5'd7, 0, 0, 0);
      step(0, 0, 0, 1, 4'd7, 0);
      checks++;
      if (alloc_tag !== 4'd1 || alloc_ready !== 1'b1 || commit_v !== 1'b0) begin
         errors++;
         $display("FAIL nodest_ghost: got tag=%0d ready=%b v=%b, expected 1 1 0", alloc_tag, alloc_ready, commit_v);
      end
      saw = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i == 0)      step(0, 0, 0, 1, 4'd0, 0);
         else if (i < 8)  step(1, 1, 5'(i), 0, 0, 0);
         else if (i < 14) step(0, 0, 0, 1, 4'(i - 7), 0);
         else             step(0, 0, 0, 0, 0, 0);
         checks++;
         if (commit_v !== e_v || mispredict !== e_misp ||
             (e_v && {commit_rename, commit_areg, commit_preg, commit_old_preg} !== {e_ren, e_areg, e_preg, e_old})) begin
            errors++;
            $display("FAIL nodest_commit: got v=%b r=%b old=%0d, expected v=%b r=%b old=%0d",
                     commit_v, commit_rename, commit_old_preg, e_v, e_ren, e_old);
         end
         if (commit_v === 1'b1 && commit_old_preg === 5'd7 && i < 4) saw = (commit_rename === 1'b0);
      end
      checks++;
      if (saw !== 1'b1) begin
         errors++;
         $display("FAIL nodest_rename: got rename-free commit=%b, expected 1", saw);
      end
   endtask

   task automatic test_reset_random();
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 5'(i), 0, 0, 0);
      step(0, 0, 0, 1, 4'd1, 0);
      step(0, 0, 0, 1, 4'd3, 0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (commit_v !== 1'b0 || mispredict !== 1'b0 || alloc_tag !== 4'd0) begin
         errors++;
         $display("FAIL midreset_async: got v=%b m=%b tag=%0d, expected 0 0 0", commit_v, mispredict, alloc_tag);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (i < 4) step(0, 0, 0, 1, 4'(i), 0);
         else step(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                   1'($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom_range(0, 19) == 0));
         checks++;
         if (commit_v !== e_v || mispredict !== e_misp ||
             (e_v && {commit_rename, commit_areg, commit_preg, commit_old_preg} !== {e_ren, e_areg, e_preg, e_old})) begin
            errors++;
            $display("FAIL random_commit: cycle %0d got v=%b m=%b r=%b old=%0d, expected v=%b m=%b r=%b old=%0d",
                     cyc, commit_v, mispredict, commit_rename, commit_old_preg, e_v, e_misp, e_ren, e_old);
         end
         checks++;
         if (alloc_ready !== m_ready() || alloc_tag !== 4'(m_next)) begin
            errors++;
            $display("FAIL random_alloc: cycle %0d got ready=%b tag=%0d, expected ready=%b tag=%0d",
                     cyc, alloc_ready, alloc_tag, m_ready(), m_next);
         end
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_full();
      test_mispredict();
      test_no_dest();
      test_reset_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
